// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX-stage HI/LO resource
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic                stall_o
);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
  state_t            state;
  logic [DATA_W-1:0] rem, quo, dvs, a_mag, b_mag, rem_n, quo_n;
  logic [DATA_W:0]   rem_sh, diff;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r, a_neg, b_neg;
  assign a_neg   = signed_i & opdata1_i[DATA_W-1];
  assign b_neg   = signed_i & opdata2_i[DATA_W-1];
  assign a_mag   = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag   = b_neg ? -opdata2_i : opdata2_i;
  // quo holds the not-yet-consumed dividend bits; its MSB shifts into the partial remainder
  assign rem_sh  = {rem, quo[DATA_W-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign rem_n   = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_n   = {quo[DATA_W-2:0], ~diff[DATA_W]};
  assign stall_o = start_i & ~ready_o & ~annul_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i & ~annul_i) begin
          busy_o <= 1'b1;
          if (opdata2_i == '0) state <= DIVZERO;
          else begin
            state <= ON;
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end
        DIVZERO: if (annul_i) begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end else begin
          state    <= END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: if (annul_i) begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end else begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            result_o <= {neg_r ? -rem_n : rem_n, neg_q ? -quo_n : quo_n};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        END: if (annul_i | ~start_i) begin
          state   <= IDLE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the EX-stage HI/LO divide resource.
- Accepts DIV/DIVU requests from EX and runs a radix-2 restoring divide, one quotient bit per cycle.
- Holds the pipeline stall while busy and presents {remainder, quotient} for the HI/LO write.
- One divide in flight at a time; EX keeps the request asserted until it consumes the result.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous and active-high.
start_i  in  1  divide request; held high by EX until it has consumed ready_o.
annul_i  in  1  cancel the request or the divide in flight (branch squash / flush).
signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
opdata1_i  in  DATA_W  dividend; sampled only on acceptance.
opdata2_i  in  DATA_W  divisor; sampled only on acceptance.
result_o  out  2*DATA_W  {remainder, quotient}; hi = [2*DATA_W-1:DATA_W], lo = [DATA_W-1:0].
ready_o  out  1  result valid.
busy_o  out  1  state != IDLE.
stall_o  out  1  start_i & ~ready_o & ~annul_i (combinational); feeds pipeline stall control.

Behaviour:
- Reset (async, any state):
  - state = IDLE; counter, dividend/divisor registers and result_o are cleared to 0.
  - ready_o = 0, busy_o = 0.
- States:
  - IDLE:
    - start_i & ~annul_i & divisor == 0 -> DIVZERO.
    - start_i & ~annul_i & divisor != 0 -> ON: latch operands, counter = 0, partial remainder = 0.
    - Otherwise stay in IDLE.
  - DIVZERO: next edge -> END with result_o = 0. No trap is raised.
  - ON: one iteration per edge.
    - Shift {rem, quo} left 1.
    - Trial-subtract divisor magnitude from rem. If the difference is non-negative, keep it and set quotient bit 1; otherwise set quotient bit 0.
    - counter++.
    - The iteration with counter == DATA_W-1 completes the result: apply sign fix-up, register result_o, go to END.
    - annul_i = 1 in ON -> IDLE next edge. result_o is unchanged; ready_o never asserts.
  - END:
    - ready_o = 1 and result_o is stable.
    - Stay in END while start_i = 1.
    - start_i = 0 -> IDLE, and ready_o drops on that edge.
    - annul_i = 1 -> IDLE.
- Signed handling (signed_i latched at acceptance):
  - Negative operands are negated to magnitudes before iterating.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Arithmetic is modulo 2^DATA_W: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Latency:
  - Normal divide: ready_o high DATA_W+1 edges after the acceptance edge (33 for DATA_W = 32).
  - Divide by zero: ready_o high 2 edges after acceptance.
- Simultaneous events:
  - annul_i has priority over start_i in every state.
  - A start_i arriving in the same cycle as the END -> IDLE edge is not accepted until the next cycle in IDLE.
- Operand changes on opdata*_i after acceptance have no effect.
- stall_o is low in any cycle where ready_o = 1, so EX advances exactly once per divide.

Test Plan:
- DIVU 100 / 7, start held -> stall_o high 33 cycles; ready_o on edge 33; result_o = {0x00000002, 0x0000000E}; start_i low -> IDLE, ready_o = 0.
- DIV -7 / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Then DIV 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- DIVU 5 / 0 -> ready_o on edge 2 via DIVZERO; result_o = 0.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- annul_i pulse at iteration 10:
  - Next edge IDLE, ready_o never asserts.
  - A following DIVU 9 / 3 completes with {0, 3} after 33 edges.
- rst asserted asynchronously mid-ON (between edges) -> outputs immediately 0, state IDLE. After release, a new request completes normally.
